// File: rtl/tdm_demux_4ch_pkg.sv
// rtl/tdm_demux_4ch_pkg.sv - shared framing constants and FSM state type for the TDM mux/demux pair
package tdm_demux_4ch_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_4ch_if.sv
// rtl/tdm_demux_4ch_if.sv - TDM slot stream in, rebuilt parallel channels and status out
interface tdm_demux_4ch_if
  import tdm_demux_4ch_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              frame_start;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;
  logic [WIDTH-1:0]  d;
  logic              frame_valid;
  logic [SLOT_W-1:0] slot;
  logic              sync_err;

  modport master (
    output din, din_valid, frame_start,
    input  a, b, c, d, frame_valid, slot, sync_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output a, b, c, d, frame_valid, slot, sync_err
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - wrapping slot counter with clear and load-to-1, shared by mux and demux
module tdm_slot_ctr
  import tdm_demux_4ch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] cnt
);

  // clear wins over load, load wins over increment; increment wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SLOT_W'(1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// rtl/tdm_demux_4ch.sv - rebuilds four parallel channels from a 4-slot TDM stream
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux_4ch_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic              ctr_clear;
  logic              ctr_load1;
  logic              ctr_inc;
  logic [WIDTH-1:0]  shadow [0:2];
  logic [2:0]        shadow_we;
  logic              out_we;
  logic              fv_nxt;
  logic              se_nxt;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (ctr_clear),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .cnt   (slot_cnt)
  );

  assign bus.slot = slot_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctr_clear = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;
    shadow_we = 3'b000;
    out_we    = 1'b0;
    fv_nxt    = 1'b0;
    se_nxt    = 1'b0;
    if (bus.din_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            shadow_we[0] = 1'b1;
            ctr_load1    = 1'b1;
            state_nxt    = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.frame_start) begin
            // a frame_start anywhere but slot 0 abandons the partial frame
            se_nxt       = (slot_cnt != '0);
            shadow_we[0] = 1'b1;
            ctr_load1    = 1'b1;
          end else if (slot_cnt == '0) begin
            se_nxt    = 1'b1;
            ctr_clear = 1'b1;
            state_nxt = ST_IDLE;
          end else if (slot_cnt == LAST_SLOT) begin
            out_we  = 1'b1;
            fv_nxt  = 1'b1;
            ctr_inc = 1'b1;
          end else begin
            shadow_we[1] = (slot_cnt == SLOT_W'(1));
            shadow_we[2] = (slot_cnt == SLOT_W'(2));
            ctr_inc      = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (shadow_we[i]) begin
          shadow[i] <= bus.din;
        end
      end
    end
  end

  // slot 3 bypasses the shadows so all four channels land in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a           <= '0;
      bus.b           <= '0;
      bus.c           <= '0;
      bus.d           <= '0;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
    end else begin
      if (out_we) begin
        bus.a <= shadow[0];
        bus.b <= shadow[1];
        bus.c <= shadow[2];
        bus.d <= bus.din;
      end
      bus.frame_valid <= fv_nxt;
      bus.sync_err    <= se_nxt;
    end
  end

endmodule
